// File: rtl/fwd_hazard_unit.sv
// EX-stage operand bypass select and load-use stall for a DEPTH-deep forwarding window.
// Define FWD_HAZARD_PERF_EN to build the saturating stall-cycle counter on stall_count.

module fwd_sel_lane #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SW     = 2
) (
    input  logic                         ex_valid,
    input  logic                         ex_use,
    input  logic [REG_AW-1:0]            ex_rs,
    input  logic [DEPTH:1]               e_prod,
    input  logic [DEPTH:1][REG_AW-1:0]   e_rd,
    output logic [SW-1:0]                sel
);
    // Scan oldest to youngest so the youngest matching producer is left in sel.
    always_comb begin
        sel = '0;
        for (int k = DEPTH; k >= 1; k--)
            if (ex_valid && ex_use && e_prod[k] && e_rd[k] == ex_rs)
                sel = SW'(k);
    end
endmodule

module fwd_hazard_unit #(
    parameter  int REG_AW   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 2,
    localparam int SW       = $clog2(DEPTH+1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_uses,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic [NUM_SRC*SW-1:0]     ex_fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_count
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } dst_t;

    // Positions p whose load data is not yet forwardable: p <= LOAD_LAT-2.
    localparam logic [DEPTH:0] STALL_WIN = (DEPTH+1)'((1 << (LOAD_LAT-1)) - 1);

    dst_t                             ex_dst;
    logic [NUM_SRC-1:0][REG_AW-1:0]   ex_rs;
    logic [NUM_SRC-1:0]               ex_uses;
    dst_t [DEPTH:1]                   e_q;

    dst_t [DEPTH:0]                   pos;
    logic [DEPTH:0]                   ld_prod;
    logic [DEPTH:1]                   e_prod;
    logic [DEPTH:1][REG_AW-1:0]       e_rd;
    logic [NUM_SRC-1:0][REG_AW-1:0]   id_rs_a;
    logic                             hazard;

    assign id_rs_a = id_rs;
    assign pos     = {e_q, ex_dst};

    always_comb begin
        for (int p = 0; p <= DEPTH; p++)
            ld_prod[p] = pos[p].valid && pos[p].we && pos[p].rd != '0 && pos[p].is_load;
        for (int k = 1; k <= DEPTH; k++) begin
            e_prod[k] = e_q[k].valid && e_q[k].we && e_q[k].rd != '0;
            e_rd[k]   = e_q[k].rd;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int p = 0; p <= DEPTH; p++)
                if (STALL_WIN[p] && id_uses[i] && ld_prod[p] && pos[p].rd == id_rs_a[i])
                    hazard = 1'b1;
    end

    assign stall = id_valid && !flush && hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_dst  <= '0;
            ex_rs   <= '0;
            ex_uses <= '0;
            e_q     <= '0;
        end else begin
            e_q[1] <= ex_dst;
            for (int k = 2; k <= DEPTH; k++)
                e_q[k] <= e_q[k-1];
            ex_dst.valid   <= id_valid && !flush && !stall;
            ex_dst.rd      <= id_rd;
            ex_dst.we      <= id_reg_write;
            ex_dst.is_load <= id_is_load;
            ex_rs          <= id_rs_a;
            ex_uses        <= id_uses;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        fwd_sel_lane #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SW(SW)) u_lane (
            .ex_valid (ex_dst.valid),
            .ex_use   (ex_uses[i]),
            .ex_rs    (ex_rs[i]),
            .e_prod   (e_prod),
            .e_rd     (e_rd),
            .sel      (ex_fwd_sel[i*SW +: SW])
        );
    end

`ifdef FWD_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`else
    assign stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit at default parameters (REG_AW=5, NUM_SRC=2, DEPTH=3, LOAD_LAT=2).

module tb_fwd_hazard_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rs = '0;
    logic [1:0]  id_uses = '0;
    logic [4:0]  id_rd = '0;
    logic        id_reg_write = 1'b0;
    logic        id_is_load = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  ex_fwd_sel;
    logic        stall;
    logic [15:0] stall_count;

`ifdef FWD_HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_uses      (id_uses),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .flush        (flush),
        .ex_fwd_sel   (ex_fwd_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs1, rs0;
        logic [1:0] uses;
        logic [4:0] rd;
        logic       we, ld, fl;
        logic [1:0] s1, s0;
        logic       st;
    } vec_t;

    function automatic vec_t mk(logic v, logic [4:0] r1, logic [4:0] r0, logic [1:0] u, logic [4:0] d,
                                logic w, logic l, logic f, logic [1:0] e1, logic [1:0] e0, logic s);
        vec_t t;
        t.valid = v; t.rs1 = r1; t.rs0 = r0; t.uses = u; t.rd = d;
        t.we = w; t.ld = l; t.fl = f; t.s1 = e1; t.s0 = e0; t.st = s;
        return t;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [4:0] r1, logic [4:0] r0, logic [1:0] u, logic [4:0] d,
                         logic w, logic l, logic f);
        id_valid = v; id_rs = {r1, r0}; id_uses = u; id_rd = d;
        id_reg_write = w; id_is_load = l; flush = f;
    endtask

    // One ID slot per vector; sel checked is for the previous vector now in EX.
    vec_t tv[33];

    initial begin
        tv[0]  = mk(1,  2, 1, 3,  5, 1, 0, 0, 0, 0, 0);
        tv[1]  = mk(1,  5, 5, 3,  6, 1, 0, 0, 0, 0, 0);
        tv[2]  = mk(0,  0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
        tv[3]  = mk(1,  2, 1, 3,  5, 1, 0, 0, 0, 0, 0);
        tv[4]  = mk(1,  4, 3, 3, 10, 1, 0, 0, 0, 0, 0);
        tv[5]  = mk(1,  5, 5, 3, 11, 1, 0, 0, 0, 0, 0);
        tv[6]  = mk(1,  5, 5, 3, 12, 1, 0, 0, 2, 2, 0);
        tv[7]  = mk(1,  5, 5, 3, 13, 1, 0, 0, 3, 3, 0);
        tv[8]  = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tv[9]  = mk(1,  0, 1, 1,  7, 1, 1, 0, 0, 0, 0);
        tv[10] = mk(1,  0, 7, 3,  8, 1, 0, 0, 0, 0, 1);
        tv[11] = mk(1,  0, 7, 3,  8, 1, 0, 0, 0, 0, 0);
        tv[12] = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 2, 0);
        tv[13] = mk(1,  0, 1, 1,  7, 1, 1, 0, 0, 0, 0);
        tv[14] = mk(1,  0, 7, 2,  8, 1, 0, 0, 0, 0, 0);
        tv[15] = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tv[16] = mk(1,  2, 1, 3,  9, 1, 0, 0, 0, 0, 0);
        tv[17] = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tv[18] = mk(1,  2, 1, 3,  9, 1, 0, 0, 0, 0, 0);
        tv[19] = mk(1,  9, 9, 3, 14, 1, 0, 0, 0, 0, 0);
        tv[20] = mk(0,  0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
        tv[21] = mk(1,  2, 1, 3,  0, 1, 0, 0, 0, 0, 0);
        tv[22] = mk(1,  0, 0, 3, 14, 1, 0, 0, 0, 0, 0);
        tv[23] = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tv[24] = mk(1,  2, 1, 3, 15, 0, 0, 0, 0, 0, 0);
        tv[25] = mk(1, 15,15, 3, 16, 1, 0, 0, 0, 0, 0);
        tv[26] = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tv[27] = mk(1,  0, 1, 1,  7, 1, 1, 0, 0, 0, 0);
        tv[28] = mk(1,  7, 7, 3, 17, 1, 0, 1, 0, 0, 0);
        tv[29] = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tv[30] = mk(1,  0, 1, 1,  7, 1, 1, 0, 0, 0, 0);
        tv[31] = mk(0,  7, 7, 3, 17, 1, 0, 0, 0, 0, 0);
        tv[32] = mk(0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

        #1 reset = 1'b1;
        #1;
        chk("rst_sel", int'(ex_fwd_sel), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_cnt", int'(stall_count), 0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            drive(tv[i].valid, tv[i].rs1, tv[i].rs0, tv[i].uses, tv[i].rd, tv[i].we, tv[i].ld, tv[i].fl);
            #1;
            chk($sformatf("v%0d_sel", i), int'(ex_fwd_sel), int'({tv[i].s1, tv[i].s0}));
            chk($sformatf("v%0d_stall", i), int'(stall), int'(tv[i].st));
        end

        // Counter: three load-use stalls from a clean reset.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); drive(1, 0, 1, 1, 7, 1, 1, 0); #1;
            chk($sformatf("cnt%0d_ld", n), int'(stall), 0);
            @(negedge clk); drive(1, 0, 7, 3, 8, 1, 0, 0); #1;
            chk($sformatf("cnt%0d_stall", n), int'(stall), 1);
            @(negedge clk); #1;
            chk($sformatf("cnt%0d_hold", n), int'(stall), 0);
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
        end
        #1;
        chk("cnt_three", int'(stall_count), PERF ? 3 : 0);

        // Async reset while a forwarded load sits in EX and its consumer stalls in ID.
        @(negedge clk); drive(1, 2, 1, 3, 5, 1, 0, 0);
        @(negedge clk); drive(1, 0, 5, 1, 7, 1, 1, 0);
        @(negedge clk); drive(1, 0, 7, 3, 8, 1, 0, 0); #1;
        chk("pre_rst_sel", int'(ex_fwd_sel), 1);
        chk("pre_rst_stall", int'(stall), 1);
        chk("pre_rst_cnt", int'(stall_count), PERF ? 3 : 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_sel", int'(ex_fwd_sel), 0);
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_cnt", int'(stall_count), 0);
        @(negedge clk);
        drive(1, 5, 5, 3, 9, 1, 0, 0);
        reset = 1'b0;
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("post_rst_sel", int'(ex_fwd_sel), 0);
        chk("post_rst_stall", int'(stall), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
